// File: rtl/rgb_lookup_arbiter.sv
// Two-requester arbiter for the single read port of the lights colour BRAM.
// Grants one read at a time, waits out the BRAM latency and returns a tagged, registered RGB word.
module rgb_lookup_arbiter #(
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 24,
  parameter int BRAM_LAT  = 1,
  parameter int FIXED_PRI = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_rgb,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, READ, WAIT} state_t;

  localparam logic [1:0] LAST_WAIT = 2'(BRAM_LAT - 1);

  state_t            state, state_nxt;
  logic [1:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              id_q;
  logic              last_id;
  logic              win_id;
  logic              last_wait;

  assign last_wait = (state == WAIT) && (wait_cnt == LAST_WAIT);

  // On a tie the requester that was not served last wins, unless fixed priority is selected.
  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    if (req0 && req1) win_id = (FIXED_PRI != 0) ? 1'b0 : ~last_id;
    else              win_id = req1;
    case (state)
      IDLE: begin
        // Grant is combinational; gate with reset so nothing is granted while held in reset.
        if ((req0 || req1) && rst_n) begin
          gnt0      = ~win_id;
          gnt1      = win_id;
          state_nxt = READ;
        end
      end
      READ:    state_nxt = WAIT;
      WAIT:    if (wait_cnt == LAST_WAIT) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      addr_q    <= '0;
      id_q      <= 1'b0;
      last_id   <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_rgb   <= '0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= last_wait;
      wait_cnt  <= (state == WAIT) ? wait_cnt + 2'd1 : 2'd0;
      if (gnt0 || gnt1) begin
        addr_q  <= gnt1 ? addr1 : addr0;
        id_q    <= gnt1;
        last_id <= gnt1;
      end
      if (last_wait) begin
        rsp_rgb <= bram_dout;
        rsp_id  <= id_q;
      end
    end
  end

  assign bram_en   = (state != IDLE);
  assign bram_addr = addr_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_rgb_lookup_arbiter.sv
// Directed bench: three arbiter instances (round-robin/LAT1, fixed-priority/LAT1, round-robin/LAT2),
// each driving its own BRAM model filled with a fixed colour table.
module tb_rgb_lookup_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] mem [8];
  initial begin
    mem[0] = 24'h000000; mem[1] = 24'h0000FF; mem[2] = 24'h12AB34; mem[3] = 24'h00FFFF;
    mem[4] = 24'hFF2010; mem[5] = 24'hA5C35A; mem[6] = 24'h00FF00; mem[7] = 24'h7E81E7;
  end

  logic        req0_a = 0, req1_a = 0, req0_b = 0, req1_b = 0, req0_c = 0, req1_c = 0;
  logic [2:0]  addr0_a = 0, addr1_a = 0, addr0_b = 0, addr1_b = 0, addr0_c = 0, addr1_c = 0;
  logic        gnt0_a, gnt1_a, en_a, vld_a, id_a, busy_a;
  logic        gnt0_b, gnt1_b, en_b, vld_b, id_b, busy_b;
  logic        gnt0_c, gnt1_c, en_c, vld_c, id_c, busy_c;
  logic [2:0]  baddr_a, baddr_b, baddr_c;
  logic [23:0] dout_a, dout_b, dout_c, rgb_a, rgb_b, rgb_c, pipe_c;

  rgb_lookup_arbiter #(.ADDR_W(3), .DATA_W(24), .BRAM_LAT(1), .FIXED_PRI(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .req0(req0_a), .addr0(addr0_a), .req1(req1_a), .addr1(addr1_a),
    .gnt0(gnt0_a), .gnt1(gnt1_a), .bram_en(en_a), .bram_addr(baddr_a), .bram_dout(dout_a),
    .rsp_valid(vld_a), .rsp_id(id_a), .rsp_rgb(rgb_a), .busy(busy_a));

  rgb_lookup_arbiter #(.ADDR_W(3), .DATA_W(24), .BRAM_LAT(1), .FIXED_PRI(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req0(req0_b), .addr0(addr0_b), .req1(req1_b), .addr1(addr1_b),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .bram_en(en_b), .bram_addr(baddr_b), .bram_dout(dout_b),
    .rsp_valid(vld_b), .rsp_id(id_b), .rsp_rgb(rgb_b), .busy(busy_b));

  rgb_lookup_arbiter #(.ADDR_W(3), .DATA_W(24), .BRAM_LAT(2), .FIXED_PRI(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .req0(req0_c), .addr0(addr0_c), .req1(req1_c), .addr1(addr1_c),
    .gnt0(gnt0_c), .gnt1(gnt1_c), .bram_en(en_c), .bram_addr(baddr_c), .bram_dout(dout_c),
    .rsp_valid(vld_c), .rsp_id(id_c), .rsp_rgb(rgb_c), .busy(busy_c));

  // BRAM models: one-cycle primitive for a/b, primitive plus output register for c.
  always_ff @(posedge clk) begin
    if (en_a) dout_a <= mem[baddr_a];
    if (en_b) dout_b <= mem[baddr_b];
    if (en_c) pipe_c <= mem[baddr_c];
    dout_c <= pipe_c;
  end

  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    // Reset held with a pending request: nothing may come out.
    req0_a = 1; addr0_a = 3'b100;
    cyc(); #1;
    chk("rst_gnt0", gnt0_a, 0);   chk("rst_gnt1", gnt1_a, 0);
    chk("rst_en", en_a, 0);       chk("rst_addr", baddr_a, 0);
    chk("rst_vld", vld_a, 0);     chk("rst_id", id_a, 0);
    chk("rst_rgb", rgb_a, 0);     chk("rst_busy", busy_a, 0);
    cyc();
    // Release; first IDLE cycle grants requester 0 (cycle T).
    cyc(); rst_n = 1; #1;
    chk("rel_gnt0", gnt0_a, 1);   chk("rel_gnt1", gnt1_a, 0);
    cyc(); req0_a = 0; #1;
    chk("rd_en", en_a, 1);        chk("rd_addr", baddr_a, 4);
    chk("rd_gnt0", gnt0_a, 0);    chk("rd_busy", busy_a, 1);
    cyc(); #1;
    chk("wt_en", en_a, 1);        chk("wt_vld", vld_a, 0);
    cyc(); #1;
    chk("s_vld", vld_a, 1);       chk("s_id", id_a, 0);
    chk("s_rgb", rgb_a, mem[4]);  chk("s_en_off", en_a, 0);  chk("s_busy", busy_a, 0);
    cyc(); #1;
    chk("s_vld_drop", vld_a, 0);  chk("s_rgb_hold", rgb_a, mem[4]);

    // Fresh reset, then both requesters held on a (round-robin) and b (fixed priority).
    cyc(); rst_n = 0;
    cyc(); rst_n = 1;
    addr0_a = 3'd1; addr1_a = 3'd6; req0_a = 1; req1_a = 1;
    addr0_b = 3'd3; addr1_b = 3'd5; req0_b = 1; req1_b = 1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_gnt0", gnt0_a, (k % 2 == 0) ? 1 : 0);
      chk("rr_gnt1", gnt1_a, (k % 2 == 1) ? 1 : 0);
      chk("fp_gnt0", gnt0_b, 1);
      chk("fp_gnt1", gnt1_b, 0);
      if (k > 0) begin
        chk("rr_vld", vld_a, 1);
        chk("rr_id", id_a, (k - 1) % 2);
        chk("rr_rgb", rgb_a, ((k - 1) % 2 == 1) ? mem[6] : mem[1]);
        chk("fp_vld", vld_b, 1);
        chk("fp_id", id_b, 0);
        chk("fp_rgb", rgb_b, mem[3]);
      end
      cyc();
      if (k == 3) begin
        req0_a = 0; req1_a = 0; req0_b = 0; req1_b = 0;
      end
      #1;
      chk("rr_busy_nognt", {30'd0, gnt0_a, gnt1_a}, 0);
      chk("fp_busy_nognt", {30'd0, gnt0_b, gnt1_b}, 0);
      cyc(); #1;
      chk("rr_gap_gnt", {30'd0, gnt0_a, gnt1_a}, 0);
      chk("rr_gap_vld", vld_a, 0);
      chk("fp_busy", busy_b, 1);
      cyc(); #1;
    end
    chk("rr_last_vld", vld_a, 1);  chk("rr_last_id", id_a, 1);
    chk("rr_last_rgb", rgb_a, mem[6]);
    chk("fp_last_id", id_b, 0);    chk("fp_idle_gnt", gnt0_b, 0);

    // Reset pulsed during WAIT aborts the read; pending req1 is granted right after release.
    cyc(); req0_a = 1; addr0_a = 3'd7; #1;
    chk("ab_gnt0", gnt0_a, 1);
    cyc(); req0_a = 0; req1_a = 1; addr1_a = 3'd5; #1;
    chk("ab_busy_gnt1", gnt1_a, 0);
    cyc(); rst_n = 0; #1;
    chk("ab_busy", busy_a, 0);     chk("ab_en", en_a, 0);
    chk("ab_vld", vld_a, 0);       chk("ab_gnt1_rst", gnt1_a, 0);
    chk("ab_addr", baddr_a, 0);
    cyc(); rst_n = 1; #1;
    chk("ab_rel_gnt1", gnt1_a, 1); chk("ab_rel_gnt0", gnt0_a, 0);
    chk("ab_no_vld", vld_a, 0);    chk("ab_rgb_clr", rgb_a, 0);
    cyc(); req1_a = 0; #1;
    chk("ab_no_vld2", vld_a, 0);
    cyc(); #1;
    chk("ab_no_vld3", vld_a, 0);
    cyc(); #1;
    chk("ab_vld", vld_a, 1);       chk("ab_id", id_a, 1);
    chk("ab_rgb", rgb_a, mem[5]);

    // Two-cycle BRAM latency on c.
    cyc(); req1_c = 1; addr1_c = 3'b010; #1;
    chk("l2_gnt1", gnt1_c, 1);     chk("l2_gnt0", gnt0_c, 0);
    cyc(); req1_c = 0; #1;
    chk("l2_en1", en_c, 1);        chk("l2_addr", baddr_c, 2);
    cyc(); #1;
    chk("l2_en2", en_c, 1);        chk("l2_vld_early1", vld_c, 0);
    cyc(); #1;
    chk("l2_en3", en_c, 1);        chk("l2_vld_early2", vld_c, 0);
    cyc(); #1;
    chk("l2_vld", vld_c, 1);       chk("l2_id", id_c, 1);
    chk("l2_rgb", rgb_c, mem[2]);  chk("l2_en_off", en_c, 0);
    chk("l2_busy", busy_c, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
